mux_rr_stream: RTL and testbench
================================

// Module: mux_rr_stream
// PURPOSE
//  4-to-1 round-robin stream multiplexer; the gathering counterpart of the 1:4 demux.
//  Merges four valid/ready input channels into one registered output stream.
//  Each output word carries a 2-bit select tag (out_sel) that names its source channel.
//  A downstream demux uses out_sel to route the word back to one of four sinks.
// PARAMETERS
//  W  8  data width of each channel and of out_data, in bits
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    synchronous reset, active-high
//  in_data    in   4*W  channel n data = in_data[n*W +: W]
//  in_valid   in   4    in_valid[n] = channel n offers a word
//  in_ready   out  4    one-hot grant; a word transfers on channel n when in_valid[n] && in_ready[n]
//  out_data   out  W    registered output word
//  out_sel    out  2    source channel of out_data
//  out_valid  out  1    out_data/out_sel hold a word
//  out_ready  in   1    downstream accepts; transfer when out_valid && out_ready
// BEHAVIOUR
//  - Clock and reset: one clock, clk. rst is synchronous and active-high and is sampled on the rising edge of clk.
//  - Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0, FSM=EMPTY.
//  - in_ready is forced to 4'b0000 in every cycle in which rst=1.
//  - FSM states: EMPTY (out_valid=0) and FULL (out_valid=1).
//  - can_load = (state==EMPTY) || out_ready.
//  - Grant g = first n with in_valid[n]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  - in_ready = can_load && |in_valid ? onehot(g) : 4'b0000. This is combinational: same-cycle grant.
//    - At most one bit of in_ready is set.
//    - in_ready never depends on an in_valid value other than through g.
//  - On a clk edge with a grant:
//    - out_data <= channel g data, out_sel <= g, out_valid <= 1, ptr <= g+1 (2-bit wrap, 3+1 -> 0).
//    - Next state is FULL.
//  - On a clk edge with no grant:
//    - If FULL && out_ready: out_valid <= 0, next state EMPTY.
//    - Otherwise all registers hold.
//  - Latency: input handshake in cycle t -> word on out_data in cycle t+1.
//  - Throughput: one word per cycle while out_ready=1; pass-through load on the drain cycle (FULL && out_ready) with no bubble.
//  - Backpressure: while FULL && !out_ready:
//    - in_ready=0000.
//    - out_data, out_sel and out_valid are held stable.
//    - ptr is held.
//  - Fairness: a channel that stays valid is granted within 4 transfers.
//  - ptr only advances on a grant; it is not touched by idle cycles.
//  - Simultaneous drain and load: handled as the load case; old word leaves, new word lands in the same edge.
//  - in_valid falling without a handshake: no effect. The word is not captured and ptr is unchanged.
//  - Reset mid-operation: a held word is discarded and out_valid=0 on the next cycle. No input transfer occurs in the reset cycle.
//  - No arithmetic beyond the 2-bit modulo-4 pointer increment; all fields are unsigned.
// TESTING
//  1. rst=1 for 2 cycles, in_valid=1111, out_ready=1
//     -> in_ready=0000 throughout; after reset out_valid=0, out_data=0, out_sel=0.
//  2. Only ch2 valid, data=8'hA5, out_ready=1
//     -> in_ready=0100 same cycle; next cycle out_valid=1, out_data=A5, out_sel=2.
//  3. in_valid=1111 held, data n=8'h10+n, out_ready=1
//     -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data=10,11,12,13,10, no bubbles.
//  4. FULL with out_sel=1, out_ready=0 for 5 cycles, all inputs valid
//     -> in_ready=0000; out_data/out_sel stable for 5 cycles.
//     -> On the cycle out_ready returns to 1, in_ready=0100 (ch2 granted).
//  5. Last grant ch1, then in_valid=1001
//     -> ch3 granted first (out_sel=3), then ch0 (out_sel=0).
//  6. FULL with out_ready=0, assert rst for 1 cycle
//     -> next cycle out_valid=0, ptr=0; then in_valid=1111 grants ch0 first.

Source files
------------

// File: rtl/mux_rr_stream.sv
// 4:1 round-robin stream mux with a registered, source-tagged output.
// Grant is combinational; one word per cycle with pass-through on drain.
module mux_rr_stream #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4*W-1:0] in_data,
  input  logic [3:0]     in_valid,
  output logic [3:0]     in_ready,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_ptr;
  logic [W-1:0]   r_data;
  logic [1:0]     r_sel;

  logic           w_can_load;
  logic           w_found;
  logic [1:0]     w_g;
  logic [1:0]     w_idx;
  logic           w_grant;
  logic [W-1:0]   w_gdata;

  assign w_can_load = (r_state == EMPTY) || out_ready;

  // Scan from the far end so the channel nearest ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_g     = r_ptr;
    w_idx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (in_valid[w_idx]) begin
        w_found = 1'b1;
        w_g     = w_idx;
      end
    end
  end

  assign w_grant  = !rst && w_can_load && w_found;
  assign in_ready = w_grant ? (4'b0001 << w_g) : 4'b0000;

  always_comb begin
    w_gdata = '0;
    unique case (1'b1)
      (w_g == 2'd0): w_gdata = in_data[0*W +: W];
      (w_g == 2'd1): w_gdata = in_data[1*W +: W];
      (w_g == 2'd2): w_gdata = in_data[2*W +: W];
      default:       w_gdata = in_data[3*W +: W];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_grant)
      w_state_nxt = FULL;
    else if (r_state == FULL && out_ready)
      w_state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_sel  <= 2'd0;
      r_ptr  <= 2'd0;
    end else if (w_grant) begin
      r_data <= w_gdata;
      r_sel  <= w_g;
      r_ptr  <= w_g + 2'd1;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = (r_state == FULL);

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: directed scenarios plus random traffic
// compared against a word-level round-robin reference model.
module tb_mux_rr_stream;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid;
  logic [3:0]     in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit       m_valid;
  bit [7:0] m_data;
  int       m_sel;
  int       m_ptr;

  always #5 clk = ~clk;

  mux_rr_stream #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic int exp_grant();
    int n;
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < 4; k++) begin
      n = (m_ptr + k) % 4;
      if (in_valid[n]) return n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant();
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  // Apply what the coming rising edge does to the model.
  function automatic void model_edge();
    int g;
    g = exp_grant();
    if (rst) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_data  = in_data[g*W +: W];
      m_sel   = g;
      m_ptr   = (g + 1) % 4;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endfunction

  task automatic drive(input bit r, input logic [3:0] v,
                       input logic [4*W-1:0] d, input bit ordy);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0000, '0, 1'b1);
    model_edge();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 4'b1111, 32'h13121110, 1'b1);
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL reset_in_ready c=%0d got=%b want=0000", c, in_ready);
      end
      model_edge();
    end
    drive(1'b0, 4'b0000, '0, 1'b1);
    checks++;
    if ({out_valid, out_sel, out_data} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%0d d=%h want 0/0/00",
               out_valid, out_sel, out_data);
    end
    model_edge();
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b0, 4'b0100, 32'h00A50000, 1'b1);
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready got=%b want=0100", in_ready);
    end
    model_edge();
    drive(1'b0, 4'b0000, '0, 1'b1);
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, 8'hA5}) begin
      failures++;
      $display("FAIL single_out got v=%b s=%0d d=%h want 1/2/a5",
               out_valid, out_sel, out_data);
    end
    model_edge();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 4'b1111, 32'h13121110, 1'b1);
      if (c > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'((c - 1) % 4) ||
            out_data !== 8'(8'h10 + (c - 1) % 4)) begin
          failures++;
          $display("FAIL b2b_seq c=%0d got v=%b s=%0d d=%h want 1/%0d/%h",
                   c, out_valid, out_sel, out_data, (c - 1) % 4,
                   8'h10 + (c - 1) % 4);
        end
      end
      model_edge();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b0, 4'b0010, 32'h00003300, 1'b1);
    model_edge();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'b1111, 32'h44434241, 1'b0);
      checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 ||
          out_sel !== 2'd1 || out_data !== 8'h33) begin
        failures++;
        $display("FAIL bp_hold c=%0d got r=%b v=%b s=%0d d=%h want 0000/1/1/33",
                 c, in_ready, out_valid, out_sel, out_data);
      end
      model_edge();
    end
    drive(1'b0, 4'b1111, 32'h44434241, 1'b1);
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_release got=%b want=0100", in_ready);
    end
    model_edge();
    drive(1'b0, 4'b0000, '0, 1'b1);
    checks++;
    if (out_sel !== 2'd2 || out_data !== 8'h43) begin
      failures++;
      $display("FAIL bp_pass got s=%0d d=%h want 2/43", out_sel, out_data);
    end
    model_edge();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b0, 4'b0010, 32'h00000100, 1'b1);
    model_edge();
    drive(1'b0, 4'b1001, 32'h300000A0, 1'b1);
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_first got=%b want=1000", in_ready);
    end
    model_edge();
    drive(1'b0, 4'b1001, 32'h310000A1, 1'b1);
    checks++;
    if (in_ready !== 4'b0001 || out_sel !== 2'd3 || out_data !== 8'h30) begin
      failures++;
      $display("FAIL wrap_second got r=%b s=%0d d=%h want 0001/3/30",
               in_ready, out_sel, out_data);
    end
    model_edge();
    drive(1'b0, 4'b0000, '0, 1'b1);
    checks++;
    if (out_sel !== 2'd0 || out_data !== 8'hA1) begin
      failures++;
      $display("FAIL wrap_out got s=%0d d=%h want 0/a1", out_sel, out_data);
    end
    model_edge();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, 4'b0100, 32'h00770000, 1'b1);
    model_edge();
    drive(1'b0, 4'b0000, '0, 1'b0);
    model_edge();
    drive(1'b1, 4'b1111, 32'h04030201, 1'b0);
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_ready got=%b want=0000", in_ready);
    end
    model_edge();
    drive(1'b0, 4'b1111, 32'h04030201, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_after got v=%b r=%b want 0/0001",
               out_valid, in_ready);
    end
    model_edge();
  endtask

  task automatic test_random();
    logic [3:0]     v;
    logic [4*W-1:0] d;
    bit             r;
    bit             o;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v = 4'($urandom);
      d = {$urandom};
      r = ($urandom_range(0, 49) == 0);
      o = ($urandom_range(0, 3) != 0);
      drive(r, v, d, o);
      checks++;
      if (in_ready !== exp_ready()) begin
        failures++;
        $display("FAIL rand_ready c=%0d got=%b want=%b", c, in_ready,
                 exp_ready());
      end
      checks++;
      if (out_valid !== m_valid || (m_valid &&
          (out_sel !== 2'(m_sel) || out_data !== m_data))) begin
        failures++;
        $display("FAIL rand_out c=%0d got v=%b s=%0d d=%h want %b/%0d/%h",
                 c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
      end
      model_edge();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
    m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
